dma_engine: RTL and testbench
=============================

Name: dma_engine

Overview:
- Executes the DMA descriptors produced by the instruction decoder when it decodes a DMA opcode (dma_en, read_addr, write_addr, byte_length).
- Moves data word by word from the source to the destination. Each word is one read then one write over a simple req/ack memory port.
- Sits beside the scoreboard. dma_busy stalls later DMA issue; dma_done retires the instruction.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Fixed at 32 (4 byte lanes).
- LEN_W, 6, meaningful low bits of byte_length.
- IO_BASE, 32'h00040000, start of the IO window (IO0..IO3).
- IO_LIMIT, 32'h00047FFF, end of the IO window, inclusive.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dma_en  in  1  descriptor valid; one-cycle pulse from the decode stage.
- read_addr  in  ADDR_W  source byte address.
- write_addr  in  ADDR_W  destination byte address.
- byte_length  in  32  transfer length in bytes. Only [LEN_W-1:0] is used; upper bits are ignored.
- dma_busy  out  1  high while a transfer is in progress.
- dma_done  out  1  one-cycle completion pulse.
- rd_req  out  1  read request.
- rd_addr  out  ADDR_W  read word address; bits [1:0] are always 0.
- rd_ack  in  1  read accepted; rd_data is valid in this cycle.
- rd_data  in  DATA_W  read data.
- wr_req  out  1  write request.
- wr_addr  out  ADDR_W  write word address; bits [1:0] are always 0.
- wr_data  out  DATA_W  write data.
- wr_strb  out  4  byte-lane enables.
- wr_ack  in  1  write accepted.

Behaviour:
- Reset: one clock, clk; reset is asynchronous, active-low on rst_n. While rst_n=0:
  - all outputs are 0 and state is IDLE;
  - internal address, count and data registers are 0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - dma_busy=0.
  - On a clk edge with dma_en=1, latch src = read_addr & ~3, dst = write_addr & ~3, len = byte_length[LEN_W-1:0].
  - Compute words = (len+3)>>2 in a LEN_W+1 bit wide register.
  - words=0 → DONE. Otherwise → RD.
- RD:
  - rd_req=1 and rd_addr=src, both held stable until rd_ack.
  - On rd_ack: capture rd_data into the data register, then → WR.
- WR:
  - wr_req=1, wr_addr=dst, wr_data=data register, all held stable until wr_ack.
  - wr_strb=4'hF, except on the last word (words==1) when len[1:0]!=0: 1→4'h1, 2→4'h3, 3→4'h7.
  - On wr_ack:
    - decrement words;
    - src += 4 and dst += 4, with ADDR_W-bit wrap-around and no error;
    - if words was 1 → DONE, else → RD.
- DONE: dma_done=1 for exactly one cycle, then → IDLE.
- dma_busy=1 in RD, WR and DONE.
- Latency:
  - descriptor accept → first rd_req: 1 cycle.
  - ack → next request: 1 cycle.
  - final wr_ack → dma_done: 1 cycle.
  - len=0: dma_done is high in the second cycle after accept.
- dma_en outside IDLE is ignored; the descriptor is dropped. The scoreboard must not issue a descriptor while dma_busy=1.
- rd_ack outside RD and wr_ack outside WR are ignored.
- Only one of rd_req and wr_req is ever high at a time.
- rst_n asserted mid-transfer: both requests drop immediately (asynchronously), there is no dma_done pulse, and the partial transfer is abandoned.

Optional Feature:
- Macro: DMA_IO_FIXED_ADDR_EN.
- Defined: a side whose latched address lies within [IO_BASE, IO_LIMIT] does not increment; it stays on the peripheral data register. The check is made once, at accept. The other side increments normally.
- Undefined: both sides always increment by 4.

Decomposition:
- Package dma_pkg:
  - state encoding: IDLE, RD, WR, DONE;
  - IO_BASE and IO_LIMIT constants;
  - strobe function last_strb(len[1:0]).
- One sub-module, dma_addr_ctr:
  - load, increment and hold-fixed address register;
  - instantiated twice, for src and dst.

Test Plan:
- len=8, src 0x00001000 → dst 0x00010000; rd_data 0xA5A5A5A5 then 0x5A5A5A5A; rd_ack delayed 0 then 2 cycles:
  - writes to 0x00010000 and 0x00010004 with strb F and matching data;
  - dma_done one cycle after the 2nd wr_ack;
  - dma_busy drops with it.
- len=6 → two writes; the second has wr_strb=4'h3.
- len=0 (byte_length=32'hFFFFFFC0, upper bits ignored):
  - no rd_req or wr_req;
  - dma_done high in the 2nd cycle after accept.
- With DMA_IO_FIXED_ADDR_EN, src 0x00042000, dst 0x00030000, len=12:
  - three reads, all at 0x00042000;
  - writes at 0x00030000, 0x00030004, 0x00030008.
  - Without the macro: reads at 0x00042000, 0x00042004, 0x00042008.
- dma_en pulsed while in WR → ignored; only the first descriptor's traffic appears. Stray rd_ack during WR → no effect.
- rst_n low while in RD with rd_req=1:
  - rd_req=0 immediately, dma_busy=0, no dma_done;
  - after release, a new len=4 descriptor completes normally.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and helpers for the descriptor-driven DMA engine.
// Holds the FSM encoding, the IO window bounds and the tail-strobe helper.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] IO_BASE  = 32'h0004_0000;
  localparam logic [31:0] IO_LIMIT = 32'h0004_7FFF;

  // Byte lanes for the final word of a transfer whose length is not word-aligned.
  function automatic logic [3:0] last_strb(input logic [1:0] len_lo);
    case (len_lo)
      2'd1:    last_strb = 4'h1;
      2'd2:    last_strb = 4'h3;
      2'd3:    last_strb = 4'h7;
      default: last_strb = 4'hF;
    endcase
  endfunction

  function automatic logic in_io_window(input logic [31:0] addr);
    in_io_window = (addr >= IO_BASE) && (addr <= IO_LIMIT);
  endfunction

endpackage

// File: rtl/dma_addr_ctr.sv
// Word address register: loads word-aligned on accept, steps by 4 unless pinned.
// Latency: new value visible the cycle after load/inc; no backpressure of its own.
module dma_addr_ctr #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              fixed_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fixed_q, fixed_d;

  always_comb begin
    addr_d  = addr_q;
    fixed_d = fixed_q;
    if (load_i) begin
      addr_d  = addr_i & ~ADDR_W'(3);
      fixed_d = fixed_i;
    end else if (inc_i && !fixed_q) begin
      addr_d = addr_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      fixed_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      fixed_q <= fixed_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/dma_engine.sv
// Word-by-word DMA mover (read then write per word); macro DMA_IO_FIXED_ADDR_EN pins IO-window sides.
// Latency: accept->rd_req 1 cycle, ack->next req 1 cycle; requests hold until their ack arrives.
module dma_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_en,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [31:0]       byte_length,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_ack
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W:0]    words_q, words_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              load, inc;
  logic              src_fixed, dst_fixed;
  logic [LEN_W:0]    words_init;
  logic              unused_len_hi;

  assign unused_len_hi = ^byte_length[31:LEN_W];
  assign words_init    = ({1'b0, byte_length[LEN_W-1:0]} + (LEN_W+1)'(3)) >> 2;

`ifdef DMA_IO_FIXED_ADDR_EN
  assign src_fixed = in_io_window(32'(read_addr & ~ADDR_W'(3)));
  assign dst_fixed = in_io_window(32'(write_addr & ~ADDR_W'(3)));
`else
  assign src_fixed = 1'b0;
  assign dst_fixed = 1'b0;
`endif

  dma_addr_ctr #(.ADDR_W(ADDR_W)) u_src_ctr (
    .clk(clk), .rst_n(rst_n), .load_i(load), .addr_i(read_addr),
    .fixed_i(src_fixed), .inc_i(inc), .addr_o(rd_addr)
  );

  dma_addr_ctr #(.ADDR_W(ADDR_W)) u_dst_ctr (
    .clk(clk), .rst_n(rst_n), .load_i(load), .addr_i(write_addr),
    .fixed_i(dst_fixed), .inc_i(inc), .addr_o(wr_addr)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    words_d  = words_q;
    data_d   = data_q;
    load     = 1'b0;
    inc      = 1'b0;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    wr_strb  = 4'h0;
    dma_done = 1'b0;
    dma_busy = 1'b1;
    case (state_q)
      IDLE: begin
        dma_busy = 1'b0;
        if (dma_en) begin
          load    = 1'b1;
          len_d   = byte_length[LEN_W-1:0];
          words_d = words_init;
          state_d = (words_init == '0) ? DONE : RD;
        end
      end
      RD: begin
        rd_req = 1'b1;
        if (rd_ack) begin
          data_d  = rd_data;
          state_d = WR;
        end
      end
      WR: begin
        wr_req  = 1'b1;
        wr_strb = (words_q == (LEN_W+1)'(1)) ? last_strb(len_q[1:0]) : 4'hF;
        if (wr_ack) begin
          inc     = 1'b1;
          words_d = words_q - (LEN_W+1)'(1);
          state_d = (words_q == (LEN_W+1)'(1)) ? DONE : RD;
        end
      end
      default: begin
        dma_done = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      data_q  <= data_d;
    end
  end

  assign wr_data = data_q;

endmodule

// File: tb/tb_dma_engine.sv
// Scoreboard bench for dma_engine: stimulus pushes expected reads/writes/done, a monitor
// acts as the memory responder and compares every handshake as it happens.
module tb_dma_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dma_en = 1'b0;
  logic [31:0] read_addr = '0, write_addr = '0, byte_length = '0;
  logic        dma_busy, dma_done, rd_req, wr_req;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        rd_ack = 1'b0, wr_ack = 1'b0;
  logic [31:0] rd_data = '0;

  dma_engine dut (
    .clk(clk), .rst_n(rst_n), .dma_en(dma_en), .read_addr(read_addr),
    .write_addr(write_addr), .byte_length(byte_length), .dma_busy(dma_busy),
    .dma_done(dma_done), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_ack(wr_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  logic [31:0] exp_rd[$];
  logic [31:0] rdat_q[$];
  int          rd_delay_q[$];
  wr_t         exp_wr[$];
  int          exp_done[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, ref_cyc = 0;
  int wr_delay = 0;
  bit stray = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_unexp(input string name, input logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %h expected no such event (cycle %0d)", name, act, cyc);
  endtask

  // Memory responder and checker
  initial begin : monitor
    int  rd_cnt, wr_cnt, cur;
    bit  prev_done;
    wr_t w;
    rd_cnt = 0; wr_cnt = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      rd_ack = 1'b0;
      wr_ack = 1'b0;
      if (!rst_n) begin
        rd_cnt = 0; wr_cnt = 0; prev_done = 0;
      end else begin
        if (rd_req && wr_req) chk("rd_wr_exclusive", 32'(rd_req & wr_req), 32'd0);
        if (rd_req) begin
          cur = (rd_delay_q.size() > 0) ? rd_delay_q[0] : 0;
          if (rd_cnt >= cur) begin
            if (rd_delay_q.size() > 0) void'(rd_delay_q.pop_front());
            rd_cnt = 0;
            rd_ack = 1'b1;
            if (exp_rd.size() == 0) begin
              fail_unexp("unexpected_rd", rd_addr);
              rd_data = 32'h0;
            end else begin
              chk("rd_addr", rd_addr, exp_rd.pop_front());
              rd_data = rdat_q.pop_front();
            end
          end else rd_cnt++;
        end else begin
          rd_cnt = 0;
          if (stray && wr_req) begin
            rd_ack  = 1'b1;
            rd_data = 32'hDEAD_BEEF;
          end
        end
        if (wr_req) begin
          if (wr_cnt >= wr_delay) begin
            wr_cnt  = 0;
            wr_ack  = 1'b1;
            ref_cyc = cyc;
            if (exp_wr.size() == 0) fail_unexp("unexpected_wr", wr_addr);
            else begin
              w = exp_wr.pop_front();
              chk("wr_addr", wr_addr, w.a);
              chk("wr_data", wr_data, w.d);
              chk("wr_strb", 32'(wr_strb), 32'(w.s));
            end
          end else wr_cnt++;
        end else wr_cnt = 0;
        if (prev_done) begin
          chk("done_one_cycle", 32'(dma_done), 32'd0);
          chk("busy_after_done", 32'(dma_busy), 32'd0);
        end
        if (dma_done) begin
          if (exp_done.size() == 0) fail_unexp("unexpected_done", 32'(cyc));
          else begin
            void'(exp_done.pop_front());
            chk("done_latency", 32'(cyc), 32'(ref_cyc + 1));
            chk("busy_with_done", 32'(dma_busy), 32'd1);
          end
        end
        prev_done = dma_done;
      end
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic issue(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                       input bit expect_rd);
    dma_en      = 1'b1;
    read_addr   = src;
    write_addr  = dst;
    byte_length = len;
    ref_cyc     = cyc;
    @(negedge clk);
    dma_en = 1'b0;
    if (expect_rd) chk("first_rd_req_latency", 32'(rd_req), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_done.size() == 0 && !dma_busy && !dma_done) break;
    end
    if (i == 200) fail_unexp({name, "_timeout"}, 32'(exp_done.size()));
  endtask

  task automatic push_rd(input logic [31:0] a, input logic [31:0] d, input int dly);
    exp_rd.push_back(a);
    rdat_q.push_back(d);
    rd_delay_q.push_back(dly);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t w;
    w.a = a; w.d = d; w.s = s;
    exp_wr.push_back(w);
  endtask

  initial begin : stim
    int i;
    repeat (2) @(negedge clk);
    chk("rst_rd_req",   32'(rd_req),   32'd0);
    chk("rst_wr_req",   32'(wr_req),   32'd0);
    chk("rst_busy",     32'(dma_busy), 32'd0);
    chk("rst_done",     32'(dma_done), 32'd0);
    chk("rst_rd_addr",  rd_addr,       32'd0);
    chk("rst_wr_addr",  wr_addr,       32'd0);
    chk("rst_wr_data",  wr_data,       32'd0);
    chk("rst_wr_strb",  32'(wr_strb),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // len=8, second read acked after 2 wait cycles
    push_rd(32'h0000_1000, 32'hA5A5_A5A5, 0);
    push_rd(32'h0000_1004, 32'h5A5A_5A5A, 2);
    push_wr(32'h0001_0000, 32'hA5A5_A5A5, 4'hF);
    push_wr(32'h0001_0004, 32'h5A5A_5A5A, 4'hF);
    exp_done.push_back(1);
    issue(32'h0000_1000, 32'h0001_0000, 32'd8, 1);
    wait_idle("len8");

    // len=6, unaligned addresses are forced to word boundaries; tail strobe 0x3
    push_rd(32'h0000_2000, 32'h1111_1111, 1);
    push_rd(32'h0000_2004, 32'h2222_2222, 0);
    push_wr(32'h0000_3000, 32'h1111_1111, 4'hF);
    push_wr(32'h0000_3004, 32'h2222_2222, 4'h3);
    exp_done.push_back(1);
    issue(32'h0000_2003, 32'h0000_3001, 32'd6, 1);
    wait_idle("len6");

    // len=0 with upper length bits set
    exp_done.push_back(1);
    issue(32'h0000_4000, 32'h0000_5000, 32'hFFFF_FFC0, 0);
    chk("len0_no_rd_req", 32'(rd_req), 32'd0);
    wait_idle("len0");

    // IO window source, len=12
    for (i = 0; i < 3; i++) begin
`ifdef DMA_IO_FIXED_ADDR_EN
      push_rd(32'h0004_2000, 32'hC000_0000 + 32'(i), 0);
`else
      push_rd(32'h0004_2000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 0);
`endif
      push_wr(32'h0003_0000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'hF);
    end
    exp_done.push_back(1);
    issue(32'h0004_2000, 32'h0003_0000, 32'd12, 1);
    wait_idle("io12");

    // dma_en and stray rd_ack while in WR are both ignored; len=3 tail strobe
    push_rd(32'h0000_5000, 32'hCAFE_BABE, 0);
    push_wr(32'h0000_6000, 32'hCAFE_BABE, 4'h7);
    exp_done.push_back(1);
    wr_delay = 3;
    stray    = 1;
    issue(32'h0000_5000, 32'h0000_6000, 32'd3, 1);
    for (i = 0; i < 20 && !wr_req; i++) @(negedge clk);
    chk("wr_req_reached", 32'(wr_req), 32'd1);
    issue(32'h0000_9000, 32'h0000_A000, 32'd8, 0);
    wait_idle("ignore_en");
    wr_delay = 0;
    stray    = 0;
    repeat (4) @(negedge clk);

    // Reset while a read is pending
    rd_delay_q.push_back(1000);
    issue(32'h0000_7000, 32'h0000_8000, 32'd8, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd_req",  32'(rd_req),   32'd0);
    chk("arst_busy",    32'(dma_busy), 32'd0);
    chk("arst_done",    32'(dma_done), 32'd0);
    chk("arst_rd_addr", rd_addr,       32'd0);
    rd_delay_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(dma_busy), 32'd0);

    push_rd(32'h0000_7000, 32'h0BAD_F00D, 0);
    push_wr(32'h0000_8000, 32'h0BAD_F00D, 4'hF);
    exp_done.push_back(1);
    issue(32'h0000_7000, 32'h0000_8000, 32'd4, 1);
    wait_idle("post_rst_len4");

    repeat (3) @(negedge clk);
    chk("rd_queue_drained",   32'(exp_rd.size()),   32'd0);
    chk("wr_queue_drained",   32'(exp_wr.size()),   32'd0);
    chk("done_queue_drained", 32'(exp_done.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

endmodule
